// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and default width for the tick-driven PWM generator.
`default_nettype none

package pwm_pkg;

  localparam int PWM_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pwm_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_shadow.sv
// pwm_shadow: pending/active period and duty registers with an update flag.
// A load coinciding with an apply goes straight to the active registers.
`default_nettype none

module pwm_shadow
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             apply,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] period_a,
  output logic [WIDTH-1:0] duty_nx
);

  logic [WIDTH-1:0] period_p;
  logic [WIDTH-1:0] duty_p;
  logic [WIDTH-1:0] period_nx;
  logic [WIDTH-1:0] duty_a;
  logic             upd;

  always_comb begin
    period_nx = period_a;
    duty_nx   = duty_a;
    if (apply) begin
      if (load) begin
        period_nx = period;
        duty_nx   = duty;
      end else if (upd) begin
        period_nx = period_p;
        duty_nx   = duty_p;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_p <= '0;
      duty_p   <= '0;
      period_a <= '0;
      duty_a   <= '0;
      upd      <= 1'b0;
    end else begin
      period_a <= period_nx;
      duty_a   <= duty_nx;
      if (load) begin
        period_p <= period;
        duty_p   <= duty;
      end
      if (apply)
        upd <= 1'b0;
      else if (load)
        upd <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_gen.sv
// pwm_gen: tick-stepped PWM with double-buffered period/duty and graceful stop.
// Optional sticky interrupt flag enabled by defining PWM_IRQ_EN.
`default_nettype none

module pwm_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  input  logic             load,
`ifdef PWM_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic             pwm,
  output logic [WIDTH-1:0] cnt,
  output logic             pend,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  pwm_state_t       state;
  pwm_state_t       state_nx;
  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] period_a;
  logic [WIDTH-1:0] duty_nx;
  logic             wrap;
  logic             apply;
  logic             pwm_nx;

  assign wrap  = (state != ST_IDLE) && tick && (cnt == period_a);
  assign apply = wrap || ((state == ST_IDLE) && en);
  assign busy  = (state != ST_IDLE);

  pwm_shadow #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .apply    (apply),
    .period   (period),
    .duty     (duty),
    .period_a (period_a),
    .duty_nx  (duty_nx)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end
      end
      ST_RUN: begin
        if (tick)
          cnt_nx = wrap ? '0 : cnt + ONE;
        if (!en)
          state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tick)
          cnt_nx = wrap ? '0 : cnt + ONE;
        // A renewed run request outranks the final wrap.
        if (en)
          state_nx = ST_RUN;
        else if (wrap)
          state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Output tracks the next visible count against the next active duty.
  assign pwm_nx = (state_nx != ST_IDLE) && (cnt_nx < duty_nx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pwm   <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pwm   <= pwm_nx;
      pend  <= wrap;
    end
  end

`ifdef PWM_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      irq <= 1'b0;
    else if (pend)
      irq <= 1'b1;
    else if (irq_clr)
      irq <= 1'b0;
  end
`endif

endmodule

`default_nettype wire

// File: doc/pwm_gen.md
# pwm_gen

Tick-driven PWM generator that sits directly downstream of the programmable timer and consumes its one-cycle `tick` strobe as a prescaled step enable. It counts ticks through a programmable period and drives a duty-cycle output. Period/duty updates are double-buffered so they take effect only at a period boundary. On disable, the current period completes before the block stops.

## Interface
- `WIDTH`, 8, width of counter, period and duty.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-cycle step strobe from the timer; the counter advances only when `tick`=1.
- `en`  in  1  run request; level-sensitive.
- `period`  in  WIDTH  last count value; the period is `period`+1 ticks.
- `duty`  in  WIDTH  number of ticks per period that `pwm` is high.
- `load`  in  1  one-cycle strobe that captures `period`/`duty` into the pending registers.
- `pwm`  out  1  PWM output, registered.
- `cnt`  out  WIDTH  current tick count, registered.
- `pend`  out  1  one-cycle period-end strobe, registered.
- `busy`  out  1  1 whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: `cnt`=0, `pwm`=0.
    - `en`=1 → RUN. On that edge, copy the pending registers to the active registers and set `cnt`=0.
  - RUN: on each `tick`, `cnt` increments.
    - When `cnt`==`period_a` and `tick`=1 (wrap), `cnt`→0, `pend`=1 for one cycle, and pending updates are applied.
    - `en`=0 → DRAIN.
  - DRAIN: counting continues exactly as in RUN.
    - `en`=1 → RUN.
    - Wrap → IDLE: `cnt`=0, `pwm`=0, `pend` still pulses.
- Shadowing:
  - `load` captures `period`/`duty` into the pending registers and sets `upd`.
  - At a wrap, or on the IDLE→RUN transition, if `upd`=1: active ← pending and `upd` clears.
  - `load` in the same cycle as a wrap applies the newly presented values at that wrap (the pending path is bypassed).
  - `load` while in IDLE is stored and applied on the next IDLE→RUN transition.
- `pwm` is a register. Each edge it takes (next state≠IDLE) && (next `cnt` < next `duty_a`), so `pwm` always corresponds to the visible `cnt`.
- Arithmetic:
  - Unsigned WIDTH-bit compare.
  - `cnt` never exceeds `period_a`.
  - If `period_a` shrinks below the current `cnt`, the change is invisible, because updates occur only at a wrap when `cnt`=0.
- Boundary cases:
  - `duty_a`=0: `pwm` is held 0.
  - `duty_a`>`period_a`: `pwm` is held 1 while running.
  - `period_a`=0: a wrap occurs on every tick, `pend` fires on every tick, and `pwm`=1 iff `duty_a`≥1.
- Reset: `cnt`, `pwm`, `pend`, `busy`, the active and pending registers, and `upd` all go to 0 immediately and asynchronously. The state goes to IDLE.

## Timing
- Latency from a `tick` edge to the `cnt`/`pwm`/`pend` update is one clock.
- `en` rising to `busy`=1 is one clock.
- Disabling: `busy` falls on the edge of the final wrap.
- `tick` with no `en` in IDLE is ignored.
- `tick` and `load` may arrive in any cycle, including back-to-back cycles.
- Simultaneous wrap and `en`=0: the wrap completes in RUN and the state moves to DRAIN. The next full period then drains.

## Configuration
- `PWM_IRQ_EN` defined: adds input `irq_clr` and output `irq`.
  - `irq` is a sticky flag, set by `pend` and cleared by `irq_clr`.
  - If set and clear occur in the same cycle, set wins.
  - Reset value 0.
- `PWM_IRQ_EN` undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `pwm_pkg` holds:
  - the state enum typedef (IDLE/RUN/DRAIN) with fixed encodings 0/1/2;
  - the default WIDTH constant.
- Sub-module `pwm_shadow` implements the pending/active double-buffer registers, the `upd` flag and the wrap-time bypass.

## Test plan
- Basic waveform: `tick`=1 constantly, `period`=4, `duty`=2, `load` pulse, then `en`=1.
  - `cnt` sequence 0,1,2,3,4,0…
  - `pwm` sequence 1,1,0,0,0 repeating.
  - `pend` fires every 5 cycles.
- Duty extremes: `duty`=0 → `pwm` constantly 0. `duty`=6 with `period`=4 → `pwm` constantly 1 while `busy`=1.
- Mid-period update: `load` with `period`=2, `duty`=1 while `cnt`=1.
  - The old 5-tick pattern completes.
  - The pattern is 1,0,0 from the next wrap.
- Graceful stop: drop `en` at `cnt`=2.
  - `cnt` continues to 4, then returns to 0.
  - `busy`→0 and `pwm`→0 on the wrap edge.
  - A final `pend` fires.
- Async reset: assert `rst` mid-period at `cnt`=3.
  - All outputs go to 0 without waiting for a clock.
  - After release, the block stays IDLE until `en`.
- Sparse tick: `tick` every 3rd cycle, `period`=1.
  - `cnt` changes only on the edge after each tick.
  - `pend` fires every 6 cycles.
  - With `PWM_IRQ_EN`, `irq` stays set until `irq_clr`.
